keypad_scan: RTL and testbench

//  Scans a 4x3 matrix keypad (rows 1-2-3 / 4-5-6 / 7-8-9 / *-0-#) and debounces it.

---
 rtl/keypad_scan.sv | 268 ++++++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: column-scanned, debounced 4x3 matrix keypad reader.
// Emits one single-cycle event per physical key press.
//
// Event interface: key_valid is a one-cycle strobe with no back-pressure.
// The consumer must take key_code and key_onehot in the key_valid cycle.
// key_code then stays unchanged until the next event.
// key_onehot is zero in every cycle except the key_valid cycle.
module keypad_scan #(
  parameter int SCAN_DIV = 2,  // clk cycles each column is driven (>=2)
  parameter int DEBOUNCE = 4   // identical frames needed to accept press/release (>=1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [2:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [9:0] key_onehot,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB     = 2'd1,
    PRESSED = 2'd2,
    REL_DB  = 2'd3
  } state_t;

  // Scan timing
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             slot_last;

  // Synchroniser, plus the matching delayed column/slot tags
  logic [3:0] row_s1, row_s2;
  logic [1:0] col_d1, col_d2;
  logic       last_d1, last_d2;

  // Per-sample decode and per-frame accumulation
  logic [2:0] hit_n;
  logic [1:0] hit_row;
  logic [1:0] hit_cnt;
  logic [3:0] hit_code;
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;
  logic [2:0] sum_cnt;
  logic [1:0] tot_cnt;
  logic [3:0] tot_code;
  logic       sample;
  logic       frame_end;
  logic       frame_none;
  logic       frame_key;

  // FSM
  state_t           state, state_n;
  logic [3:0]       cand, cand_n;
  logic [DEB_W-1:0] deb, deb_n;
  logic [DEB_W-1:0] deb_inc;
  logic             deb_reached;
  logic             emit;

  // Map a (row, column) position to its key code: digits 0-9, '*'=10, '#'=11.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    if (r == 2'd3) begin
      case (c)
        2'd0:    k = 4'd10;
        2'd1:    k = 4'd0;
        default: k = 4'd11;
      endcase
    end else begin
      k = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return k;
  endfunction

  assign slot_last = (div_cnt == DIV_W'(SCAN_DIV - 1));

  // Exactly one column is driven low; col_idx resets to 0, giving 3'b110.
  assign col_out = ~(3'b001 << col_idx);

  // Column slot timer: SCAN_DIV cycles per column, columns visited 0->1->2->0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (slot_last) begin
      div_cnt <= '0;
      col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Two-flop row synchroniser. The column index and the slot-end flag are
  // delayed by the same two stages, so each synchronised row sample is
  // attributed to the column that was actually driven when it was captured.
  // Rows idle high (pull-ups), so the synchroniser resets to all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      col_d1  <= 2'd0;
      col_d2  <= 2'd0;
      last_d1 <= 1'b0;
      last_d2 <= 1'b0;
    end else begin
      row_s1  <= row_in;
      row_s2  <= row_s1;
      col_d1  <= col_idx;
      col_d2  <= col_d1;
      last_d1 <= slot_last;
      last_d2 <= last_d1;
    end
  end

  assign sample    = last_d2;
  assign frame_end = sample && (col_d2 == 2'd2);

  // Count the low rows in the current sample and decode a lone hit.
  always_comb begin
    hit_n   = 3'd0;
    hit_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        hit_n   = hit_n + 3'd1;
        hit_row = 2'(r);
      end
    end
    hit_cnt  = (hit_n >= 3'd2) ? 2'd2 : hit_n[1:0];
    hit_code = map_key(hit_row, col_d2);
  end

  // Merge this sample with the earlier columns of the frame; counts saturate at 2 (MULTI).
  always_comb begin
    sum_cnt    = {1'b0, acc_cnt} + {1'b0, hit_cnt};
    tot_cnt    = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    tot_code   = (acc_cnt != 2'd0) ? acc_code : hit_code;
    frame_none = (tot_cnt == 2'd0);
    frame_key  = (tot_cnt == 2'd1);
  end

  // Frame accumulator: collects columns 0 and 1 and clears at the column-2 sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      if (frame_end) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_cnt  <= tot_cnt;
        acc_code <= tot_code;
      end
    end
  end

  // The debounce count saturates at DEBOUNCE.
  always_comb begin
    deb_inc     = (deb >= DEB_W'(DEBOUNCE)) ? deb : deb + DEB_W'(1);
    deb_reached = (deb_inc == DEB_W'(DEBOUNCE));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= 4'd0;
      deb   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      deb   <= deb_n;
    end
  end

  // FSM next state: moves only at frame end; emit marks an accepted press.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    deb_n   = deb;
    emit    = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_key) begin
            cand_n = tot_code;
            if (DEBOUNCE == 1) begin
              emit    = 1'b1;
              deb_n   = '0;
              state_n = PRESSED;
            end else begin
              deb_n   = DEB_W'(1);
              state_n = DEB;
            end
          end
        end
        DEB: begin
          if (frame_key && (tot_code == cand)) begin
            if (deb_reached) begin
              emit    = 1'b1;
              deb_n   = '0;
              state_n = PRESSED;
            end else begin
              deb_n = deb_inc;
            end
          end else if (frame_key) begin
            cand_n = tot_code;
            deb_n  = DEB_W'(1);
          end else begin
            deb_n   = '0;
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (frame_none) begin
            if (DEBOUNCE == 1) begin
              deb_n   = '0;
              state_n = IDLE;
            end else begin
              deb_n   = DEB_W'(1);
              state_n = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (frame_none) begin
            if (deb_reached) begin
              deb_n   = '0;
              state_n = IDLE;
            end else begin
              deb_n = deb_inc;
            end
          end else begin
            deb_n   = '0;
            state_n = PRESSED;
          end
        end
        default: begin
          deb_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  // Event outputs: one-cycle strobe and one-hot; the code is held until the next event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
      key_onehot <= 10'd0;
    end else begin
      key_valid  <= emit;
      key_onehot <= (emit && (cand_n <= 4'd9)) ? (10'd1 << cand_n) : 10'd0;
      if (emit) begin
        key_code <= cand_n;
      end
    end
  end

  assign key_held = (state == PRESSED) || (state == REL_DB);

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed test of keypad_scan with a behavioural 4x3 key matrix.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [2:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic [9:0] key_onehot;
  logic       key_held;

  // Key index = row*3 + col: '1'=0 '2'=1 '3'=2 '5'=4 '7'=6 '9'=8 '*'=9 '#'=11
  logic [11:0] keys_down;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int run_len  = 0;
  int max_run  = 0;
  int leak     = 0;
  logic [3:0] last_code   = 4'd0;
  logic [9:0] last_onehot = 10'd0;

  keypad_scan #(.SCAN_DIV(2), .DEBOUNCE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_onehot (key_onehot),
    .key_held   (key_held)
  );

  // Clock
  always #5 clk = ~clk;

  // Key matrix: a row is pulled low while a pressed key on it shares the driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (keys_down[r*3+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Event monitor: records each pulse, its width, and any one-hot outside a pulse.
  always @(negedge clk) begin
    if (key_valid) begin
      pulses      = pulses + 1;
      last_code   = key_code;
      last_onehot = key_onehot;
      run_len     = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
      if (key_onehot != 10'd0) leak = leak + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (n * 6) @(negedge clk);
  endtask

  // Wait (bounded) until col_out shows the given pattern at a falling edge.
  task automatic wait_col(input logic [2:0] pat, output logic found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (col_out == pat) found = 1'b1;
    end
  endtask

  initial begin
    logic found;
    rst       = 1'b1;
    keys_down = 12'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_col", 32'(col_out), 32'h6);
    check_eq("rst_valid", 32'(key_valid), 32'h0);
    check_eq("rst_code", 32'(key_code), 32'h0);
    check_eq("rst_onehot", 32'(key_onehot), 32'h0);
    check_eq("rst_held", 32'(key_held), 32'h0);
    rst = 1'b0;
    wait_frames(2);
    check_eq("idle_no_pulse", 32'(pulses), 32'd0);

    // Test 1: hold '5' for 10 frames
    keys_down[4] = 1'b1;
    wait_frames(10);
    check_eq("t1_pulses", 32'(pulses), 32'd1);
    check_eq("t1_code", 32'(last_code), 32'd5);
    check_eq("t1_onehot", 32'(last_onehot), 32'h020);
    check_eq("t1_held", 32'(key_held), 32'h1);
    keys_down = 12'd0;
    wait_frames(6);
    check_eq("t1_rel_held", 32'(key_held), 32'h0);
    check_eq("t1_code_hold", 32'(key_code), 32'd5);
    check_eq("t1_rel_pulses", 32'(pulses), 32'd1);

    // Test 2: '3' in alternate frames, then steady
    for (int i = 0; i < 3; i++) begin
      keys_down[2] = 1'b1;
      repeat (6) @(negedge clk);
      keys_down[2] = 1'b0;
      repeat (6) @(negedge clk);
    end
    check_eq("t2_alt_none", 32'(pulses), 32'd1);
    keys_down[2] = 1'b1;
    repeat (18) @(negedge clk);
    check_eq("t2_three_frames", 32'(pulses), 32'd1);
    repeat (18) @(negedge clk);
    check_eq("t2_pulses", 32'(pulses), 32'd2);
    check_eq("t2_code", 32'(last_code), 32'd3);
    check_eq("t2_onehot", 32'(last_onehot), 32'h008);
    keys_down = 12'd0;
    wait_frames(6);

    // Test 3: hold '7', short release gives no repeat, full release does
    keys_down[6] = 1'b1;
    wait_frames(100);
    check_eq("t3_first", 32'(pulses), 32'd3);
    check_eq("t3_code", 32'(last_code), 32'd7);
    keys_down = 12'd0;
    repeat (12) @(negedge clk);
    keys_down[6] = 1'b1;
    wait_frames(10);
    check_eq("t3_short_rel", 32'(pulses), 32'd3);
    keys_down = 12'd0;
    wait_frames(5);
    keys_down[6] = 1'b1;
    wait_frames(10);
    check_eq("t3_second", 32'(pulses), 32'd4);
    check_eq("t3_onehot", 32'(last_onehot), 32'h080);
    keys_down = 12'd0;
    wait_frames(6);

    // Test 4: '1' and '2' together, then release '2'
    keys_down[0] = 1'b1;
    keys_down[1] = 1'b1;
    wait_frames(10);
    check_eq("t4_multi", 32'(pulses), 32'd4);
    keys_down[1] = 1'b0;
    wait_frames(6);
    check_eq("t4_pulses", 32'(pulses), 32'd5);
    check_eq("t4_code", 32'(last_code), 32'd1);
    check_eq("t4_onehot", 32'(last_onehot), 32'h002);
    keys_down = 12'd0;
    wait_frames(6);

    // Test 5: '*' then '#'
    keys_down[9] = 1'b1;
    wait_frames(8);
    check_eq("t5_star_pulses", 32'(pulses), 32'd6);
    check_eq("t5_star_code", 32'(last_code), 32'd10);
    check_eq("t5_star_onehot", 32'(last_onehot), 32'h000);
    keys_down = 12'd0;
    wait_frames(6);
    keys_down[11] = 1'b1;
    wait_frames(8);
    check_eq("t5_hash_pulses", 32'(pulses), 32'd7);
    check_eq("t5_hash_code", 32'(last_code), 32'd11);
    check_eq("t5_hash_onehot", 32'(last_onehot), 32'h000);
    keys_down = 12'd0;
    wait_frames(6);

    // Test 6: reset while debouncing '9' with three good frames counted
    wait_col(3'b011, found);
    check_eq("t6_align_c2", 32'(found), 32'h1);
    wait_col(3'b110, found);
    check_eq("t6_align_c0", 32'(found), 32'h1);
    keys_down[8] = 1'b1;
    repeat (22) @(negedge clk);
    check_eq("t6_pre_rst", 32'(pulses), 32'd7);
    rst = 1'b1;
    #1;
    check_eq("t6_col", 32'(col_out), 32'h6);
    check_eq("t6_valid", 32'(key_valid), 32'h0);
    check_eq("t6_code", 32'(key_code), 32'h0);
    check_eq("t6_onehot", 32'(key_onehot), 32'h0);
    check_eq("t6_held", 32'(key_held), 32'h0);
    repeat (2) @(negedge clk);
    keys_down = 12'd0;
    rst = 1'b0;
    wait_frames(6);
    check_eq("t6_no_pulse", 32'(pulses), 32'd7);
    keys_down[8] = 1'b1;
    wait_frames(8);
    check_eq("t6_redeb_pulses", 32'(pulses), 32'd8);
    check_eq("t6_redeb_code", 32'(last_code), 32'd9);
    check_eq("t6_redeb_onehot", 32'(last_onehot), 32'h200);
    keys_down = 12'd0;
    wait_frames(2);

    // Pulse shape over the whole run
    check_eq("pulse_width", 32'(max_run), 32'd1);
    check_eq("onehot_leak", 32'(leak), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
